// File: rtl/cs_pkg.sv
// ---------------------------------------------------------------------------
// cs_pkg
// Shared constants and types for the computational-system (CS) filter.
//   X_W       : input sample width
//   Y_W       : filter result (Y) width
//   WIN       : filter window length in samples
//   OVF_CNT_W : width of the dropped-sample counter
//   SKIP_DEF  : results discarded after reset while the window fills
// ---------------------------------------------------------------------------
package cs_pkg;

    localparam int X_W       = 8;
    localparam int Y_W       = 10;
    localparam int WIN       = 9;
    localparam int OVF_CNT_W = 16;

    // The first WIN-1 results are computed from a partly filled window.
    localparam int SKIP_DEF  = WIN - 1;

    typedef logic [Y_W-1:0] y_t;

endpackage

// File: rtl/cs_y_fifo.sv
// ---------------------------------------------------------------------------
// cs_y_fifo
// Synchronous FIFO holding accepted Y results until the sink takes them.
// The caller is responsible for never pushing into a full FIFO unless it
// pops in the same cycle, and for never popping an empty FIFO.
// Ports:
//   clk      : clock, all logic on posedge
//   reset    : synchronous, active-high; clears pointers and level
//   i_push   : write i_data at the write pointer this cycle
//   i_pop    : retire the head entry this cycle
//   i_data   : entry to write
//   o_data   : head entry (mem[rd_ptr]); meaningless when o_empty
//   o_level  : current occupancy, 0..DEPTH
//   o_full   : o_level == DEPTH
//   o_empty  : o_level == 0
// Memory contents are not reset; only the bookkeeping is.
// ---------------------------------------------------------------------------
module cs_y_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leave the level unchanged.
            if (i_push && !i_pop) begin
                r_level <= r_level + 1'b1;
            end else if (i_pop && !i_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);

endmodule

// File: rtl/cs_y_collector.sv
// ---------------------------------------------------------------------------
// cs_y_collector
// Downstream stage of the CS filter. Discards the first SKIP results after
// reset (window warm-up), buffers the rest in a FIFO, drains them over a
// valid/ready handshake and flags samples dropped because the FIFO was full.
//
// Optional feature macro: CS_OVF_CNT_EN
//   defined   : ovf_cnt port and 16-bit saturating dropped-sample counter
//   undefined : port and counter absent; the sticky ovf flag remains
//
// Ports:
//   clk        : clock, all logic on posedge
//   reset      : synchronous, active-high
//   y_in       : CS result, sampled at posedge when y_en is high
//   y_en       : one strobe per new upstream sample
//   out_data   : FIFO head entry
//   out_valid  : FIFO non-empty
//   out_ready  : sink accepts out_data this cycle
//   level      : current FIFO occupancy
//   ovf        : sticky, at least one sample dropped since reset
//   ovf_cnt    : dropped-sample count, saturating (CS_OVF_CNT_EN only)
//
// Handshake: a transfer happens on a posedge where out_valid and out_ready
// are both high. out_valid never depends on out_ready, and out_data stays
// stable while out_valid is high and out_ready is low. A pushed entry is
// visible on out_data the cycle after the push (no same-cycle bypass).
// ---------------------------------------------------------------------------
module cs_y_collector
    import cs_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int SKIP  = SKIP_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [Y_W-1:0]           y_in,
    input  logic                     y_en,
    output logic [Y_W-1:0]           out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
`ifdef CS_OVF_CNT_EN
    ,
    output logic [OVF_CNT_W-1:0]     ovf_cnt
`endif
);

    // Wide enough to hold SKIP itself, including SKIP == 0.
    localparam int SKW = $clog2(SKIP + 2);

    logic [SKW-1:0] r_skip_cnt;
    logic           r_ovf;

    logic           w_warm;
    logic           w_push_req;
    logic           w_pop;
    logic           w_push;
    logic           w_drop;
    logic           w_full;
    logic           w_empty;

    assign w_warm     = (r_skip_cnt == SKW'(SKIP));
    assign w_push_req = y_en & w_warm;
    assign w_pop      = out_valid & out_ready;
    // A full FIFO still accepts a sample if the head leaves in the same cycle.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    // Warm-up counter: counts strobes up to SKIP, then holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_skip_cnt <= '0;
        end else if (y_en && !w_warm) begin
            r_skip_cnt <= r_skip_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

`ifdef CS_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] r_ovf_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_cnt <= '0;
        end else if (w_drop && (r_ovf_cnt != '1)) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

    cs_y_fifo #(
        .DEPTH (DEPTH),
        .W     (Y_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (y_in),
        .o_data  (out_data),
        .o_level (level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid = ~w_empty;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_cs_y_collector.sv
// ---------------------------------------------------------------------------
// tb_cs_y_collector
// Randomised and directed stimulus for cs_y_collector, checked against a
// queue-based reference model of the collector's rules.
// ---------------------------------------------------------------------------
module tb_cs_y_collector;

    localparam int DEPTH = 16;
    localparam int SKIP  = 8;
    localparam int YW    = 10;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [YW-1:0] y_in = '0;
    logic          y_en = 1'b0;
    logic          out_ready = 1'b0;
    logic [YW-1:0] out_data;
    logic          out_valid;
    logic [4:0]    level;
    logic          ovf;
`ifdef CS_OVF_CNT_EN
    logic [15:0]   ovf_cnt;
`endif

    always #5 clk = ~clk;

    cs_y_collector #(
        .DEPTH (DEPTH),
        .SKIP  (SKIP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .y_in      (y_in),
        .y_en      (y_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .ovf       (ovf)
`ifdef CS_OVF_CNT_EN
        ,
        .ovf_cnt   (ovf_cnt)
`endif
    );

    // ---------------- reference model state ----------------
    logic [YW-1:0] exp_q[$];
    int            m_cnt;
    int            m_seen;      // strobes seen since reset, capped at SKIP
    int            m_ovf;
    int            m_ovfcnt;
    bit            mon_en = 1'b0;

    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Drives one cycle of inputs, then updates the model with the effect of
    // that posedge.
    task automatic step(input bit en, input logic [YW-1:0] y, input bit rdy, input bit rst = 1'b0);
        bit pop;
        reset     = rst;
        y_en      = en;
        y_in      = y;
        out_ready = rdy;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_cnt    = 0;
            m_seen   = 0;
            m_ovf    = 0;
            m_ovfcnt = 0;
            mon_en   = 1'b1;
        end else begin
            pop = (m_cnt > 0) && rdy;
            if (en) begin
                if (m_seen < SKIP) begin
                    m_seen++;
                end else if (m_cnt < DEPTH || pop) begin
                    exp_q.push_back(y);
                    m_cnt++;
                end else begin
                    m_ovf = 1;
                    if (m_ovfcnt < 65535) m_ovfcnt++;
                end
            end
            if (pop) m_cnt--;
        end
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", 32'(out_valid), 32'(m_cnt != 0));
            check("level", 32'(level), 32'(m_cnt));
            check("ovf", 32'(ovf), 32'(m_ovf));
`ifdef CS_OVF_CNT_EN
            check("ovf_cnt", 32'(ovf_cnt), 32'(m_ovfcnt));
`endif
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL out_data: got %0d with nothing expected at %0t", out_data, $time);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);

        // Warm-up: 8 strobes discarded, 9th kept.
        for (int i = 0; i < SKIP; i++) step(1, 10'h3FF, 1);
        check("warm_valid", 32'(out_valid), 32'd0);
        check("warm_level", 32'(level), 32'd0);
        step(1, 10'd100, 1);
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_data", 32'(out_data), 32'd100);
        step(0, '0, 1);

        // Streaming 0..19 with sink always ready.
        for (int i = 0; i < 20; i++) step(1, YW'(i), 1);
        step(0, '0, 1);
        check("stream_drained", 32'(out_valid), 32'd0);

        // Fill past full with the sink stalled.
        for (int i = 0; i < 18; i++) step(1, YW'(i), 0);
        check("full_level", 32'(level), 32'd16);
        check("full_ovf", 32'(ovf), 32'd1);
`ifdef CS_OVF_CNT_EN
        check("full_ovf_cnt", 32'(ovf_cnt), 32'd2);
`endif
        // Push and pop together while full.
        step(1, 10'd500, 1);
        check("full_pp_level", 32'(level), 32'd16);
`ifdef CS_OVF_CNT_EN
        check("full_pp_ovf_cnt", 32'(ovf_cnt), 32'd2);
`endif
        for (int i = 0; i < 17; i++) step(0, '0, 1);
        check("drain_empty", 32'(out_valid), 32'd0);

        // Reset with entries buffered and a strobe on the reset edge.
        for (int i = 0; i < 5; i++) step(1, YW'(200 + i), 0);
        step(1, 10'd333, 0, 1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < SKIP; i++) step(1, YW'($urandom_range(0, 1023)), 1);
        check("rst_skip_level", 32'(level), 32'd0);
        step(1, 10'd77, 1);
        check("rst_first_data", 32'(out_data), 32'd77);
        step(0, '0, 1);

        // Backpressure: out_ready alternating with continuous strobes.
        for (int i = 0; i < 40; i++) step(1, YW'($urandom_range(0, 1023)), (i % 2) == 0);
        for (int i = 0; i < DEPTH + 2; i++) step(0, '0, 1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, YW'($urandom_range(0, 1023)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 149) == 0);
        end
        for (int i = 0; i < DEPTH + 2; i++) step(0, '0, 1);
        check("final_empty", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cs_y_collector.md
# cs_y_collector

Downstream stage of the computational-system (CS) filter. Captures each 10-bit Y result, discards the results produced before the 9-sample window is full, and buffers the valid ones in a synchronous FIFO. A valid/ready handshake drains the FIFO toward the result sink, and overflows are flagged.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- SKIP, 8, number of y_en strobes discarded after reset (window warm-up)

Ports:
- clk  input  1  clock, all logic on posedge
- reset  input  1  reset, synchronous, active-high; clock clk
- y_in  input  10  CS result Y; stable at posedge when y_en high
- y_en  input  1  one strobe per new upstream sample
- out_data  output  10  FIFO head entry
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  sink accepts out_data this cycle
- level  output  $clog2(DEPTH)+1  current occupancy
- ovf  output  1  sticky: at least one sample dropped since reset
- ovf_cnt  output  16  dropped-sample count (only with CS_OVF_CNT_EN)

## Operation
- Warm-up counter `skip_cnt` counts y_en strobes from 0 to SKIP, then saturates. `warm` = (skip_cnt == SKIP).
- A strobe arriving while `warm` is low is discarded. It does not set ovf.
- push_req = y_en & warm.
- pop = out_valid & out_ready.
- push = push_req & (level < DEPTH | pop). Write y_in at wr_ptr, then advance wr_ptr.
- pop advances rd_ptr.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- level update:
  - +1 on push only
  - −1 on pop only
  - unchanged on both or neither
- Full with push_req and pop in the same cycle: both occur and level stays DEPTH.
- Full with push_req and no pop: the sample is dropped, ovf ← 1, and ovf_cnt increments, saturating at 16'hFFFF.
- Empty with out_ready high: nothing happens. out_data is don't-care when out_valid is low.
- Empty with push: there is no same-cycle bypass. The entry appears as out_data the next cycle.
- out_data = mem[rd_ptr]. It is held stable while out_valid is high and out_ready is low.
- Arithmetic: y_in is stored unmodified. There is no saturation or rounding in this block.

## Timing
- Reset values: out_valid 0, level 0, ovf 0, ovf_cnt 0, skip_cnt 0, wr_ptr 0, rd_ptr 0. FIFO memory is not reset.
- Latency: y_en accepted at edge n → out_valid high after edge n (visible in cycle n+1).
- Throughput: one push and one pop per cycle sustained.
- Reset mid-operation: all buffered entries are lost and out_valid drops after the reset edge. Warm-up restarts, so the next SKIP strobes are discarded. A y_en asserted together with reset is ignored.
- The upstream Y update occurs mid-cycle, so y_in is sampled only at posedge.

## Configuration
- CS_OVF_CNT_EN defined:
  - ovf_cnt port and 16-bit saturating counter are present.
  - The counter is cleared by reset.
- CS_OVF_CNT_EN undefined:
  - Port and counter are removed.
  - ovf (sticky flag) remains.
  - All other behaviour is identical.

## Structure
- Package cs_pkg holds:
  - X_W = 8, Y_W = 10, WIN = 9
  - OVF_CNT_W = 16
- SKIP defaults to WIN−1 via cs_pkg.
- Sub-module cs_y_fifo holds the synchronous FIFO: memory, pointers, level, full/empty.
- Top cs_y_collector holds:
  - warm-up counter
  - push gating
  - overflow flag and counter
  - handshake outputs

## Test plan
- Reset, then 8 strobes y_in=10'h3FF with out_ready=1 → out_valid stays 0, level 0, ovf 0. The 9th strobe y_in=10'd100 → out_valid=1 next cycle with out_data=100.
- After warm-up, 20 strobes y_in=0..19 with out_ready=1 every cycle → outputs 0..19 in order, level ≤ 1, no gaps after the first.
- After warm-up, out_ready=0 and 18 strobes y_in=0..17 (DEPTH=16):
  - level=16, ovf=1, ovf_cnt=2.
  - Draining yields 0..15, then out_valid=0.
- At full, simultaneous strobe y_in=500 and out_ready=1 → head pops, 500 is written, level stays 16, ovf_cnt unchanged.
- With 5 entries buffered, assert reset for 1 cycle with y_en=1:
  - next cycle out_valid=0, level=0, ovf=0.
  - the next 8 strobes are discarded.
- Backpressure: out_ready toggling 1,0,1,0 with continuous strobes → out_data holds while out_ready is low, no duplicates or losses, ordering preserved.
